// File: rtl/bp_fpga_host_pkg.sv
// Shared host-link definitions for the FPGA host NBF (network bridge format)
// channel: the packet width macro, the packet struct declaration macro and the
// opcode encoding. A packet is opcode in the low byte, then address, then data,
// so it is serialised least-significant byte first.
`ifndef BP_FPGA_HOST_PKG_SV
`define BP_FPGA_HOST_PKG_SV

`define BP_FPGA_HOST_NBF_WIDTH(addr_mp, data_mp) (8 + (addr_mp) + (data_mp))

`define DECLARE_BP_FPGA_HOST_NBF_S(addr_mp, data_mp) \
  typedef struct packed { \
    logic [(data_mp)-1:0]     data; \
    logic [(addr_mp)-1:0]     addr; \
    bp_fpga_host_nbf_opcode_e opcode; \
  } bp_fpga_host_nbf_s

package bp_fpga_host_pkg;

  localparam int nbf_opcode_width_gp = 8;

  typedef enum logic [nbf_opcode_width_gp-1:0] {
    e_fpga_host_nbf_write_4 = 8'h02,
    e_fpga_host_nbf_write_8 = 8'h03,
    e_fpga_host_nbf_read_4  = 8'h12,
    e_fpga_host_nbf_read_8  = 8'h13,
    e_fpga_host_nbf_fence   = 8'hFE,
    e_fpga_host_nbf_finish  = 8'hFF
  } bp_fpga_host_nbf_opcode_e;

endpackage

`endif

// File: rtl/nbf_byte_serializer.sv
// Parallel-in, byte-out serialiser for the response path.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   i_data/i_v        packet to send (accepted when o_ready_and is high)
//   o_ready_and       high only while idle
//   o_byte/o_v        current byte, LSB-first, with valid
//   i_ready_and       downstream byte acceptance
module nbf_byte_serializer
  #(parameter int width_p = 112,
    localparam int bytes_lp = width_p / 8)
  (input  logic               clk,
   input  logic               reset,
   input  logic [width_p-1:0] i_data,
   input  logic               i_v,
   output logic               o_ready_and,
   output logic [7:0]         o_byte,
   output logic               o_v,
   input  logic               i_ready_and);

  localparam int idx_width_lp = (bytes_lp > 1) ? $clog2(bytes_lp) : 1;
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(bytes_lp - 1);

  typedef enum logic {e_tx_idle, e_tx_send} tx_state_e;

  tx_state_e                r_state, w_state_n;
  logic [idx_width_lp-1:0]  r_idx, w_idx_n;
  logic [width_p-1:0]       r_data;
  logic                     w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= e_tx_idle;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      if (w_load) r_data <= i_data;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_load      = 1'b0;
    o_ready_and = 1'b0;
    o_v         = 1'b0;
    case (r_state)
      e_tx_idle: begin
        o_ready_and = 1'b1;
        if (i_v) begin
          w_load    = 1'b1;
          w_idx_n   = '0;
          w_state_n = e_tx_send;
        end
      end
      e_tx_send: begin
        o_v = 1'b1;
        if (i_ready_and) begin
          if (r_idx == last_idx_lp) begin
            w_idx_n   = '0;
            w_state_n = e_tx_idle;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Byte mux written as a decoded loop so every slice index is a constant.
  always_comb begin
    o_byte = '0;
    for (int b = 0; b < bytes_lp; b++) begin
      if (r_idx == idx_width_lp'(b)) o_byte = r_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/nbf_uart_framer.sv
// Bridges a UART byte stream and the NBF packet interface.
// RX: bytes are assembled LSB-first into a packet, held until handshaken;
//     extra bytes while full are dropped (overflow pulse) and a stalled partial
//     packet is discarded after timeout_cycles_p idle cycles (timeout pulse).
// TX: response packets are serialised byte by byte by nbf_byte_serializer.
// Ports:
//   clk, reset                         clock; asynchronous active-high reset
//   rx_v_i, rx_i                       received UART byte strobe and data
//   nbf_o, nbf_v_o, nbf_ready_and_i    assembled command packet out
//   nbf_i, nbf_v_i, nbf_ready_and_o    response packet in
//   tx_o, tx_v_o, tx_ready_and_i       byte stream to UART TX
//   rx_overflow_o, rx_timeout_o        single-cycle error pulses
module nbf_uart_framer
  import bp_fpga_host_pkg::*;
  #(parameter int nbf_addr_width_p = 40,
    parameter int nbf_data_width_p = 64,
    parameter int timeout_cycles_p = 4096,
    localparam int nbf_width_lp = `BP_FPGA_HOST_NBF_WIDTH(nbf_addr_width_p, nbf_data_width_p),
    localparam int nbf_bytes_lp = nbf_width_lp / 8)
  (input  logic                    clk,
   input  logic                    reset,
   input  logic                    rx_v_i,
   input  logic [7:0]              rx_i,
   output logic [nbf_width_lp-1:0] nbf_o,
   output logic                    nbf_v_o,
   input  logic                    nbf_ready_and_i,
   input  logic [nbf_width_lp-1:0] nbf_i,
   input  logic                    nbf_v_i,
   output logic                    nbf_ready_and_o,
   output logic [7:0]              tx_o,
   output logic                    tx_v_o,
   input  logic                    tx_ready_and_i,
   output logic                    rx_overflow_o,
   output logic                    rx_timeout_o);

  `DECLARE_BP_FPGA_HOST_NBF_S(nbf_addr_width_p, nbf_data_width_p);

  localparam int count_width_lp = $clog2(nbf_bytes_lp + 1);
  localparam int timer_width_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [count_width_lp-1:0] last_byte_lp  = count_width_lp'(nbf_bytes_lp - 1);
  localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_cycles_p - 1);

  typedef enum logic {e_rx_collect, e_rx_full} rx_state_e;

  rx_state_e                 r_rx_state, w_rx_state_n;
  logic [count_width_lp-1:0] r_count, w_count_n, w_wr_idx;
  logic [timer_width_lp-1:0] r_timer, w_timer_n;
  bp_fpga_host_nbf_s         r_rx_pkt;
  logic                      w_wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= e_rx_collect;
      r_count    <= '0;
      r_timer    <= '0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_count    <= w_count_n;
      r_timer    <= w_timer_n;
    end
  end

  // Byte write into the packet register, decoded per byte lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_pkt <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < nbf_bytes_lp; b++) begin
        if (w_wr_idx == count_width_lp'(b)) r_rx_pkt[8*b +: 8] <= rx_i;
      end
    end
  end

  // The idle timer only runs with a partial packet in hand; it is cleared on
  // every received byte and whenever the count returns to zero, so it is
  // always zero while idle or full.
  always_comb begin
    w_rx_state_n  = r_rx_state;
    w_count_n     = r_count;
    w_timer_n     = r_timer;
    w_wr_en       = 1'b0;
    w_wr_idx      = r_count;
    nbf_v_o       = 1'b0;
    rx_overflow_o = 1'b0;
    rx_timeout_o  = 1'b0;
    case (r_rx_state)
      e_rx_collect: begin
        if (rx_v_i) begin
          w_wr_en   = 1'b1;
          w_timer_n = '0;
          if (r_count == last_byte_lp) begin
            w_count_n    = '0;
            w_rx_state_n = e_rx_full;
          end else begin
            w_count_n = r_count + 1'b1;
          end
        end else if (r_count != '0) begin
          if (r_timer == timer_last_lp) begin
            rx_timeout_o = 1'b1;
            w_count_n    = '0;
            w_timer_n    = '0;
          end else begin
            w_timer_n = r_timer + 1'b1;
          end
        end
      end
      e_rx_full: begin
        nbf_v_o = 1'b1;
        if (nbf_ready_and_i) begin
          w_rx_state_n = e_rx_collect;
          // A byte landing in the release cycle starts the next packet.
          if (rx_v_i) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = '0;
            w_count_n = count_width_lp'(1);
          end
        end else if (rx_v_i) begin
          rx_overflow_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign nbf_o = r_rx_pkt;

  nbf_byte_serializer #(.width_p(nbf_width_lp)) tx_serializer
    (.clk         (clk),
     .reset       (reset),
     .i_data      (nbf_i),
     .i_v         (nbf_v_i),
     .o_ready_and (nbf_ready_and_o),
     .o_byte      (tx_o),
     .o_v         (tx_v_o),
     .i_ready_and (tx_ready_and_i));

endmodule

// File: tb/tb_nbf_uart_framer.sv
// Scoreboard bench for nbf_uart_framer: stimulus pushes expected packets and
// bytes into queues, independent monitors pop and compare on each handshake.
module tb_nbf_uart_framer;

  localparam int nbfW          = 112;
  localparam int nbfBytes      = 14;
  localparam int timeoutCycles = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             rx_v_i = 1'b0;
  logic [7:0]       rx_i = '0;
  logic [nbfW-1:0]  nbf_o;
  logic             nbf_v_o;
  logic             nbf_ready_and_i = 1'b0;
  logic [nbfW-1:0]  nbf_i = '0;
  logic             nbf_v_i = 1'b0;
  logic             nbf_ready_and_o;
  logic [7:0]       tx_o;
  logic             tx_v_o;
  logic             tx_ready_and_i = 1'b0;
  logic             rx_overflow_o;
  logic             rx_timeout_o;

  always #5 clk = ~clk;

  nbf_uart_framer #(.nbf_addr_width_p(40), .nbf_data_width_p(64),
                    .timeout_cycles_p(timeoutCycles)) dut
    (.clk(clk), .reset(reset), .rx_v_i(rx_v_i), .rx_i(rx_i),
     .nbf_o(nbf_o), .nbf_v_o(nbf_v_o), .nbf_ready_and_i(nbf_ready_and_i),
     .nbf_i(nbf_i), .nbf_v_i(nbf_v_i), .nbf_ready_and_o(nbf_ready_and_o),
     .tx_o(tx_o), .tx_v_o(tx_v_o), .tx_ready_and_i(tx_ready_and_i),
     .rx_overflow_o(rx_overflow_o), .rx_timeout_o(rx_timeout_o));

  logic [nbfW-1:0] nbfExp[$];
  logic [7:0]      txExp[$];
  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [nbfW-1:0] makePkt(input logic [7:0] op,
                                              input logic [39:0] addr,
                                              input logic [63:0] data);
    return {data, addr, op};
  endfunction

  function automatic logic [7:0] pktByte(input logic [nbfW-1:0] p, input int i);
    logic [nbfW-1:0] t;
    t = p >> (8 * i);
    return t[7:0];
  endfunction

  // Packet monitor: compares every accepted command packet with the queue head.
  always @(negedge clk) begin
    if (!reset && nbf_v_o && nbf_ready_and_i) begin
      if (nbfExp.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL nbf unexpected packet: got %0h, expected none", nbf_o);
      end else begin
        checkOutput("nbf packet", nbf_o, nbfExp.pop_front());
      end
    end
  end

  // Byte monitor: compares every accepted TX byte with the queue head.
  always @(negedge clk) begin
    if (!reset && tx_v_o && tx_ready_and_i) begin
      if (txExp.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL tx unexpected byte: got %0h, expected none", tx_o);
      end else begin
        checkOutput("tx byte", tx_o, txExp.pop_front());
      end
    end
  end

  task automatic sendRxByte(input logic [7:0] b);
    rx_v_i = 1'b1;
    rx_i   = b;
    @(posedge clk); #1;
    rx_v_i = 1'b0;
    rx_i   = '0;
  endtask

  task automatic applyStimulus(input logic [nbfW-1:0] pkt);
    for (int i = 0; i < nbfBytes; i++) sendRxByte(pktByte(pkt, i));
  endtask

  task automatic acceptPacket();
    nbf_ready_and_i = 1'b1;
    @(posedge clk); #1;
    nbf_ready_and_i = 1'b0;
    @(negedge clk);
    checkOutput("nbf_v_o low after handshake", nbf_v_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [nbfW-1:0] p1, p2, p3, p4, p5, p6, junk, r1, r2;
    logic [7:0] r1Bytes[14];
    int ovCount, pulseAt, pulseCount, cyc, viol;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset nbf_v_o", nbf_v_o, 0);
    checkOutput("reset tx_v_o", tx_v_o, 0);
    checkOutput("reset nbf_ready_and_o", nbf_ready_and_o, 1);
    checkOutput("reset rx_overflow_o", rx_overflow_o, 0);
    checkOutput("reset rx_timeout_o", rx_timeout_o, 0);
    checkOutput("reset nbf_o", nbf_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // write_8 packet, latency and field layout
    p1 = makePkt(8'h03, 40'h00_8000_0000, 64'hAB);
    nbfExp.push_back(p1);
    for (int i = 0; i < nbfBytes - 1; i++) sendRxByte(pktByte(p1, i));
    rx_v_i = 1'b1;
    rx_i   = pktByte(p1, nbfBytes - 1);
    @(negedge clk);
    checkOutput("nbf_v_o before final edge", nbf_v_o, 0);
    @(posedge clk); #1;
    rx_v_i = 1'b0;
    @(negedge clk);
    checkOutput("nbf_v_o one cycle after byte 13", nbf_v_o, 1);
    checkOutput("field opcode", nbf_o[7:0], 8'h03);
    checkOutput("field addr", nbf_o[47:8], 40'h00_8000_0000);
    checkOutput("field data", nbf_o[111:48], 64'hAB);
    @(posedge clk); #1;
    acceptPacket();

    // overflow while held
    p2 = makePkt(8'h13, 40'h12_3456_7890, 64'h0);
    nbfExp.push_back(p2);
    applyStimulus(p2);
    ovCount = 0;
    for (int k = 0; k < 50; k++) begin
      if (k == 10 || k == 25 || k == 40) begin
        rx_v_i = 1'b1;
        rx_i   = 8'h5A;
      end
      @(negedge clk);
      if (rx_overflow_o) ovCount++;
      if (k == 10 || k == 25 || k == 40) checkOutput("overflow pulse", rx_overflow_o, 1);
      @(posedge clk); #1;
      rx_v_i = 1'b0;
    end
    checkOutput("overflow pulse count", ovCount, 3);
    checkOutput("nbf_o unchanged after overflow", nbf_o, p2);
    checkOutput("nbf_v_o held", nbf_v_o, 1);
    acceptPacket();

    // byte arriving in the handshake cycle starts the next packet
    p3 = makePkt(8'h02, 40'h00_8000_0010, 64'hDEAD_BEEF);
    p4 = makePkt(8'h03, 40'h00_8000_0020, 64'h1122_3344_5566_7788);
    nbfExp.push_back(p3);
    nbfExp.push_back(p4);
    applyStimulus(p3);
    nbf_ready_and_i = 1'b1;
    rx_v_i = 1'b1;
    rx_i   = pktByte(p4, 0);
    @(negedge clk);
    checkOutput("no overflow in handshake cycle", rx_overflow_o, 0);
    @(posedge clk); #1;
    nbf_ready_and_i = 1'b0;
    rx_v_i = 1'b0;
    for (int i = 1; i < nbfBytes; i++) sendRxByte(pktByte(p4, i));
    @(negedge clk);
    checkOutput("next packet complete after 13 more bytes", nbf_v_o, 1);
    @(posedge clk); #1;
    acceptPacket();

    // timeout after 5 bytes and 16 idle cycles
    for (int i = 0; i < 5; i++) sendRxByte(8'hC0 + 8'(i));
    pulseAt = 0;
    pulseCount = 0;
    for (int k = 1; k <= timeoutCycles + 4; k++) begin
      @(negedge clk);
      if (rx_timeout_o) begin
        pulseCount++;
        if (pulseAt == 0) pulseAt = k;
      end
      @(posedge clk); #1;
    end
    checkOutput("timeout pulse cycle", pulseAt, 16);
    checkOutput("timeout pulse count", pulseCount, 1);
    p5 = makePkt(8'h13, 40'h00_8000_0100, 64'h0);
    nbfExp.push_back(p5);
    applyStimulus(p5);
    @(negedge clk);
    checkOutput("packet after timeout", nbf_v_o, 1);
    @(posedge clk); #1;
    acceptPacket();

    // TX serialisation with a toggling ready
    r1 = makePkt(8'h03, 40'h00_8000_0040, 64'h0123_4567_89AB_CDEF);
    r1Bytes = '{8'h03, 8'h40, 8'h00, 8'h00, 8'h80, 8'h00, 8'hEF,
                8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    for (int i = 0; i < nbfBytes; i++) txExp.push_back(r1Bytes[i]);
    @(negedge clk);
    checkOutput("tx idle ready", nbf_ready_and_o, 1);
    @(posedge clk); #1;
    nbf_v_i = 1'b1;
    nbf_i   = r1;
    @(posedge clk); #1;
    nbf_v_i = 1'b0;
    nbf_i   = '0;
    tx_ready_and_i = 1'b0;
    cyc = 0;
    viol = 0;
    while (txExp.size() > 0 && cyc < 100) begin
      tx_ready_and_i = ~tx_ready_and_i;
      @(negedge clk);
      if (nbf_ready_and_o) viol++;
      @(posedge clk); #1;
      cyc++;
    end
    tx_ready_and_i = 1'b0;
    checkOutput("tx bytes drained within budget", txExp.size(), 0);
    checkOutput("nbf_ready_and_o low while sending", viol, 0);
    @(negedge clk);
    checkOutput("tx ready after final byte", nbf_ready_and_o, 1);
    checkOutput("tx_v_o low after final byte", tx_v_o, 0);
    @(posedge clk); #1;

    // reset in the middle of concurrent RX and TX traffic
    r2 = makePkt(8'h13, 40'h00_8000_0080, 64'hFEDC_BA98_7654_3210);
    txExp.push_back(8'h13);
    txExp.push_back(8'h80);
    txExp.push_back(8'h00);
    txExp.push_back(8'h00);
    txExp.push_back(8'h80);
    junk = makePkt(8'h03, 40'h11, 64'h22);
    nbf_v_i = 1'b1;
    nbf_i   = r2;
    @(posedge clk); #1;
    nbf_v_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_v_i = 1'b1;
      rx_i   = pktByte(junk, i);
      tx_ready_and_i = (i >= 3);
      @(posedge clk); #1;
    end
    rx_v_i = 1'b0;
    tx_ready_and_i = 1'b0;
    checkOutput("tx busy before reset", tx_v_o, 1);
    checkOutput("rx partial before reset", nbf_o[63:0], junk[63:0]);
    reset = 1'b1;
    #1;
    checkOutput("mid reset nbf_v_o", nbf_v_o, 0);
    checkOutput("mid reset tx_v_o", tx_v_o, 0);
    checkOutput("mid reset nbf_ready_and_o", nbf_ready_and_o, 1);
    checkOutput("mid reset rx_overflow_o", rx_overflow_o, 0);
    checkOutput("mid reset rx_timeout_o", rx_timeout_o, 0);
    checkOutput("mid reset nbf_o", nbf_o, 0);
    checkOutput("mid reset tx_o", tx_o, 0);
    checkOutput("tx bytes before reset", txExp.size(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    p6 = makePkt(8'h03, 40'h00_8000_0200, 64'hCAFE);
    nbfExp.push_back(p6);
    applyStimulus(p6);
    @(negedge clk);
    checkOutput("fresh packet after reset", nbf_v_o, 1);
    @(posedge clk); #1;
    acceptPacket();

    checkOutput("nbf packets all seen", nbfExp.size(), 0);
    checkOutput("tx bytes all seen", txExp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
